mmio_xbar_multi: RTL and testbench
==================================

Name: mmio_xbar_multi

Overview:
Parametrised MMIO crossbar sitting between the CPU data-memory port and on-board peripherals such as the hex display, LEDs and switches.
- Decodes word addresses into N_OUT writable output registers, N_IN read-only input channels and one status register.
- Applies byte-lane masks to writes, so sub-word stores are legal.
- Returns registered read data one cycle after the request.
- Flags unmapped accesses in a sticky error bit.

Parameters:
ADDR_W, 30, word-address width of the MMIO port
DATA_W, 32, data width; must be a multiple of 8; mask width is DATA_W/8
N_OUT, 4, number of writable output registers (channel 0 = hex display)
N_IN, 2, number of read-only input channels
BASE_ADDR, 0, word address of output register 0
SYNC_STAGES, 2, synchroniser depth on each input channel (>=2)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_mmio_addr  input  ADDR_W  word address
i_mmio_data  input  DATA_W  write data
i_mmio_mask  input  DATA_W/8  byte-lane write enables
i_mmio_wren  input  1  write request, single-cycle
i_mmio_rden  input  1  read request, single-cycle
o_mmio_data  output  DATA_W  read data, valid when o_mmio_rvalid
o_mmio_rvalid  output  1  read response strobe
o_out_data  output  N_OUT*DATA_W  output register contents, channel k at [k*DATA_W +: DATA_W]
o_out_wren  output  N_OUT  one-cycle update strobe per output channel
i_in_data  input  N_IN*DATA_W  asynchronous peripheral inputs
o_err  output  1  sticky unmapped-access flag

Behaviour:
Clock and reset:
- One clock (i_clk); reset is asynchronous and active-low (i_rst_n).
- Reset clears all output registers, o_out_wren, o_mmio_data, o_mmio_rvalid, o_err and every synchroniser flop to 0.
- Reset mid-transaction drops any pending read response; no rvalid follows deassertion.

Address map (offset = addr - BASE_ADDR, unsigned; addr < BASE_ADDR is unmapped):
- 0..N_OUT-1: output register k.
- N_OUT..N_OUT+N_IN-1: input channel j (read-only).
- N_OUT+N_IN: STATUS. Bit 0 = err; other bits read 0.
- Everything else is unmapped.

Write, i_mmio_wren=1 at edge t:
- Output register hit: for each byte b with mask[b]=1, shadow[k] byte b takes data byte b at edge t. o_out_data reflects the new value after t. o_out_wren[k]=1 for exactly the cycle after t, aligned with the updated data.
- mask=0: no update, no strobe, no error.
- Write to an input channel or an unmapped address: no state change except err<=1.
- STATUS write with mask[0]=1 and data[0]=1 clears err (write-1-to-clear). If a new error and a clear occur in the same cycle, set wins.

Read, i_mmio_rden=1 at edge t:
- At t+1, o_mmio_rvalid=1 and o_mmio_data holds the selected value: shadow[k], the synchronised input j, or STATUS.
- Unmapped read returns 0, rvalid=1, and sets err.
- When rvalid=0, o_mmio_data=0.
- Back-to-back reads give rvalid on consecutive cycles; there is no stall.

Simultaneous rden and wren to the same register: read returns the pre-write value. Write strobe and error behave as for a lone write.

Input channels:
- Each bit passes through SYNC_STAGES flops before it is readable.
- Latency from an i_in_data change to a read seeing it: SYNC_STAGES cycles, plus the 1-cycle read latency.

Outputs: all are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared include mmio_defs.vh holds: XBAR base address, STATUS offset macro, err bit position, hexd channel index (0).
- System-level address constants move there from system_top.
- Sub-module mmio_sync: SYNC_STAGES-deep, DATA_W-wide synchroniser, instantiated once per input channel via generate.
- Decode and byte-merge stay in the top module.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0; release -> outputs remain 0, no rvalid.
- Full write: addr=BASE+0, data=32'h0000_BEEF, mask=4'hF, wren -> next cycle o_out_wren=4'b0001 and channel 0=32'h0000_BEEF. A read of BASE+0 -> rvalid one cycle later, data 32'h0000_BEEF.
- Masked write: channel 1 preset to 32'h1122_3344; write data=32'hAABB_CCDD, mask=4'b0101 -> channel 1=32'h11BB_33DD. A mask=0 write -> no strobe, value unchanged.
- Input sync: set i_in_data channel 0 to 32'h5A -> reads within SYNC_STAGES cycles return the old value; reads after that return 32'h5A at addr BASE+N_OUT.
- Error: read BASE+N_OUT+N_IN+1 -> rvalid with data 0 and o_err=1. Write STATUS data=1, mask=4'h1 -> o_err=0. Clear in the same cycle as a new unmapped write -> o_err stays 1.
- Read/write collision: channel 2=32'h1, simultaneous read and write of 32'h2 to channel 2 -> read returns 32'h1, channel 2 becomes 32'h2. Assert reset during a pending read -> no rvalid afterwards.

Source files
------------

// File: rtl/mmio_xbar_multi_pkg.sv
// Shared MMIO crossbar constants: system base address, status layout and register-kind encoding.
package mmio_xbar_multi_pkg;

    localparam int unsigned XBAR_BASE_ADDR = 0;
    localparam int unsigned ERR_BIT        = 0;

    typedef enum logic [1:0] {
        REG_OUT    = 2'd0,
        REG_IN     = 2'd1,
        REG_STATUS = 2'd2,
        REG_NONE   = 2'd3
    } reg_kind_e;

    // STATUS sits directly after the last input channel.
    function automatic int status_offset(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

endpackage

// File: rtl/mmio_sync.sv
// Multi-flop synchroniser for one asynchronous peripheral input word.
module mmio_sync #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= i_data;
            for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign o_data = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/mmio_xbar_multi.sv
// MMIO crossbar: decodes word addresses to output registers, synchronised inputs and a status word.
module mmio_xbar_multi
    import mmio_xbar_multi_pkg::*;
#(
    parameter int                ADDR_W      = 30,
    parameter int                DATA_W      = 32,
    parameter int                N_OUT       = 4,
    parameter int                N_IN        = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(XBAR_BASE_ADDR),
    parameter int                SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [ADDR_W-1:0]       i_mmio_addr,
    input  logic [DATA_W-1:0]       i_mmio_data,
    input  logic [DATA_W/8-1:0]     i_mmio_mask,
    input  logic                    i_mmio_wren,
    input  logic                    i_mmio_rden,
    output logic [DATA_W-1:0]       o_mmio_data,
    output logic                    o_mmio_rvalid,
    output logic [N_OUT*DATA_W-1:0] o_out_data,
    output logic [N_OUT-1:0]        o_out_wren,
    input  logic [N_IN*DATA_W-1:0]  i_in_data,
    output logic                    o_err
);

    localparam int MASK_W     = DATA_W / 8;
    localparam int STATUS_OFF = status_offset(N_OUT, N_IN);

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [MASK_W-1:0] lanes
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < MASK_W; b++) begin
            if (lanes[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    logic [DATA_W-1:0] shadow_p1 [N_OUT];
    logic [DATA_W-1:0] sync_data [N_IN];
    logic [N_OUT-1:0]  out_wren_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              err_p1;

    logic [ADDR_W-1:0] offset;
    reg_kind_e         kind;
    logic [N_OUT-1:0]  out_hit;
    logic [N_IN-1:0]   in_hit;
    logic [DATA_W-1:0] rd_sel;
    logic              wr_active;
    logic              err_set;
    logic              err_clr;

    for (genvar j = 0; j < N_IN; j++) begin : g_sync
        mmio_sync #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_data  (i_in_data[j*DATA_W +: DATA_W]),
            .o_data  (sync_data[j])
        );
    end

    // Stage p0: address decode and read-data selection
    always_comb begin
        offset  = i_mmio_addr - BASE_ADDR;
        kind    = REG_NONE;
        out_hit = '0;
        in_hit  = '0;
        if (i_mmio_addr >= BASE_ADDR) begin
            if (offset < ADDR_W'(N_OUT))             kind = REG_OUT;
            else if (offset < ADDR_W'(N_OUT + N_IN)) kind = REG_IN;
            else if (offset == ADDR_W'(STATUS_OFF))  kind = REG_STATUS;
        end
        for (int k = 0; k < N_OUT; k++) begin
            out_hit[k] = (kind == REG_OUT) && (offset == ADDR_W'(k));
        end
        for (int j = 0; j < N_IN; j++) begin
            in_hit[j] = (kind == REG_IN) && (offset == ADDR_W'(N_OUT + j));
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (out_hit[k]) rd_sel = shadow_p1[k];
        end
        for (int j = 0; j < N_IN; j++) begin
            if (in_hit[j]) rd_sel = sync_data[j];
        end
        if (kind == REG_STATUS) rd_sel[ERR_BIT] = err_p1;
    end

    // An all-zero mask makes a write a complete no-op, including error reporting.
    assign wr_active = i_mmio_wren && (|i_mmio_mask);
    assign err_set   = (wr_active && (kind == REG_IN || kind == REG_NONE))
                     || (i_mmio_rden && kind == REG_NONE);
    assign err_clr   = i_mmio_wren && (kind == REG_STATUS)
                     && i_mmio_mask[ERR_BIT/8] && i_mmio_data[ERR_BIT];

    // Stage p1: registered shadows, strobes, read response and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_OUT; k++) shadow_p1[k] <= '0;
            out_wren_p1 <= '0;
            rdata_p1    <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                out_wren_p1[k] <= wr_active && out_hit[k];
                if (wr_active && out_hit[k]) begin
                    shadow_p1[k] <= byte_merge(shadow_p1[k], i_mmio_data, i_mmio_mask);
                end
            end
            vld_p1   <= i_mmio_rden;
            rdata_p1 <= i_mmio_rden ? rd_sel : '0;
            if (err_set)      err_p1 <= 1'b1;
            else if (err_clr) err_p1 <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign o_out_data[k*DATA_W +: DATA_W] = shadow_p1[k];
    end

    assign o_out_wren    = out_wren_p1;
    assign o_mmio_data   = rdata_p1;
    assign o_mmio_rvalid = vld_p1;
    assign o_err         = err_p1;

endmodule

// File: tb/tb_mmio_xbar_multi.sv
// Randomised bench for mmio_xbar_multi with an address-map level reference model.
module tb_mmio_xbar_multi;

    localparam int          ADDR_W      = 30;
    localparam int          DATA_W      = 32;
    localparam int          N_OUT       = 4;
    localparam int          N_IN        = 2;
    localparam int          SYNC_STAGES = 2;
    localparam int          BASE_I      = 8;
    localparam logic [29:0] BASE        = 30'(BASE_I);
    localparam logic [29:0] STATUS_A    = 30'(BASE_I + N_OUT + N_IN);

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic [ADDR_W-1:0]       addr  = '0;
    logic [DATA_W-1:0]       data  = '0;
    logic [DATA_W/8-1:0]     mask  = '0;
    logic                    wren  = 1'b0;
    logic                    rden  = 1'b0;
    logic [N_IN*DATA_W-1:0]  in_data = '0;
    logic [DATA_W-1:0]       rdata;
    logic                    rvalid;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_wren;
    logic                    err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_shadow [N_OUT];
    logic [3:0]  m_owren;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_err;
    logic [63:0] m_hist [$];

    mmio_xbar_multi #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .N_OUT       (N_OUT),
        .N_IN        (N_IN),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_mmio_addr   (addr),
        .i_mmio_data   (data),
        .i_mmio_mask   (mask),
        .i_mmio_wren   (wren),
        .i_mmio_rden   (rden),
        .o_mmio_data   (rdata),
        .o_mmio_rvalid (rvalid),
        .o_out_data    (out_data),
        .o_out_wren    (out_wren),
        .i_in_data     (in_data),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_OUT; k++) m_shadow[k] = '0;
        m_owren  = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_hist   = {};
        for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back('0);
    endtask

    // One clock edge of the address map, described region by region.
    task automatic model_step();
        longint      off;
        logic [63:0] seen;
        logic [31:0] lanes;
        bit          is_out, is_in, is_st, unm, wr;
        off    = longint'(addr) - longint'(BASE_I);
        is_out = (off >= 0) && (off < N_OUT);
        is_in  = (off >= N_OUT) && (off < N_OUT + N_IN);
        is_st  = (off == N_OUT + N_IN);
        unm    = !(is_out || is_in || is_st);
        wr     = wren && (mask != 0);
        seen   = m_hist[SYNC_STAGES-1];

        m_rvalid = rden;
        m_rdata  = '0;
        if (rden) begin
            if (is_out)     m_rdata = m_shadow[int'(off)];
            else if (is_in) m_rdata = seen[int'(off - N_OUT)*32 +: 32];
            else if (is_st) m_rdata = {31'b0, m_err};
        end

        m_owren = '0;
        if (wr && is_out) begin
            for (int b = 0; b < 4; b++) lanes[b*8 +: 8] = mask[b] ? 8'hFF : 8'h00;
            m_shadow[int'(off)] = (m_shadow[int'(off)] & ~lanes) | (data & lanes);
            m_owren[int'(off)]  = 1'b1;
        end

        if ((wr && (is_in || unm)) || (rden && unm))     m_err = 1'b1;
        else if (wren && is_st && mask[0] && data[0])  m_err = 1'b0;

        m_hist.push_front(in_data);
        void'(m_hist.pop_back());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        logic [127:0] exp_out;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N_OUT; k++) exp_out[k*32 +: 32] = m_shadow[k];
            cmp("out_data", out_data, exp_out);
            cmp("out_wren", 128'(out_wren), 128'(m_owren));
            cmp("rvalid", 128'(rvalid), 128'(m_rvalid));
            cmp("rdata", 128'(rdata), 128'(m_rdata));
            cmp("err", 128'(err), 128'(m_err));
        end
    end

    task automatic drive(input logic w, input logic r, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        wren = w;
        rden = r;
        addr = a;
        data = d;
        mask = m;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wren    = 1'($urandom);
            rden    = 1'($urandom);
            addr    = 30'($urandom);
            data    = $urandom;
            mask    = 4'($urandom);
            in_data = {$urandom, $urandom};
        end
        @(negedge clk);
        cmp("rst_out_data", out_data, '0);
        cmp("rst_rvalid", 128'(rvalid), '0);
        cmp("rst_err", 128'(err), '0);
        in_data = '0;
        idle();
        rst_n = 1'b1;
        idle();
        idle();
        cmp("post_rst_rvalid", 128'(rvalid), '0);
        cmp("post_rst_out_wren", 128'(out_wren), '0);

        drive(1'b1, 1'b0, BASE, 32'h0000_BEEF, 4'hF);
        cmp("full_wr_strobe", 128'(out_wren), 128'h1);
        cmp("full_wr_ch0", 128'(out_data[31:0]), 128'h0000_BEEF);
        drive(1'b0, 1'b1, BASE, '0, '0);
        cmp("rd_ch0_vld", 128'(rvalid), 128'h1);
        cmp("rd_ch0_data", 128'(rdata), 128'h0000_BEEF);

        drive(1'b1, 1'b0, BASE + 30'd1, 32'h1122_3344, 4'hF);
        drive(1'b1, 1'b0, BASE + 30'd1, 32'hAABB_CCDD, 4'b0101);
        cmp("masked_wr_ch1", 128'(out_data[63:32]), 128'h11BB_33DD);
        cmp("masked_wr_strobe", 128'(out_wren), 128'h2);
        drive(1'b1, 1'b0, BASE + 30'd1, 32'hFFFF_FFFF, 4'h0);
        cmp("mask0_strobe", 128'(out_wren), '0);
        cmp("mask0_ch1", 128'(out_data[63:32]), 128'h11BB_33DD);

        in_data[31:0] = 32'h5A;
        drive(1'b0, 1'b1, BASE + 30'(N_OUT), '0, '0);
        cmp("sync_rd0_old", 128'(rdata), '0);
        drive(1'b0, 1'b1, BASE + 30'(N_OUT), '0, '0);
        cmp("sync_rd1_old", 128'(rdata), '0);
        drive(1'b0, 1'b1, BASE + 30'(N_OUT), '0, '0);
        cmp("sync_rd2_new", 128'(rdata), 128'h5A);

        drive(1'b0, 1'b1, STATUS_A + 30'd1, '0, '0);
        cmp("unmapped_rd_vld", 128'(rvalid), 128'h1);
        cmp("unmapped_rd_data", 128'(rdata), '0);
        cmp("unmapped_rd_err", 128'(err), 128'h1);
        drive(1'b0, 1'b1, STATUS_A, '0, '0);
        cmp("status_rd", 128'(rdata), 128'h1);
        drive(1'b1, 1'b0, STATUS_A, 32'h1, 4'h1);
        cmp("err_clear", 128'(err), '0);
        drive(1'b1, 1'b0, BASE - 30'd1, 32'h1234, 4'hF);
        cmp("below_base_wr_err", 128'(err), 128'h1);
        drive(1'b1, 1'b0, STATUS_A, 32'h0, 4'hF);
        cmp("status_wr0_keeps_err", 128'(err), 128'h1);
        drive(1'b1, 1'b1, STATUS_A, 32'h1, 4'h1);
        cmp("status_rd_clr_data", 128'(rdata), 128'h1);
        cmp("status_rd_clr_err", 128'(err), '0);

        drive(1'b1, 1'b0, BASE + 30'd2, 32'h1, 4'hF);
        drive(1'b1, 1'b1, BASE + 30'd2, 32'h2, 4'hF);
        cmp("collide_rdata", 128'(rdata), 128'h1);
        cmp("collide_ch2", 128'(out_data[95:64]), 128'h2);
        cmp("collide_strobe", 128'(out_wren), 128'h4);

        wren = 1'b0;
        rden = 1'b1;
        addr = BASE;
        #2 rst_n = 1'b0;
        @(negedge clk);
        cmp("rst_pending_rvalid", 128'(rvalid), '0);
        rden  = 1'b0;
        rst_n = 1'b1;
        idle();
        cmp("rst_pending_after", 128'(rvalid), '0);
        cmp("rst_pending_ch0", 128'(out_data[31:0]), '0);

        for (int i = 0; i < 3000; i++) begin
            logic [29:0] a;
            if ($urandom_range(0, 9) == 0) a = 30'($urandom);
            else a = 30'(BASE_I - 2 + int'($urandom_range(0, N_OUT + N_IN + 4)));
            if ($urandom_range(0, 15) == 0) in_data = {$urandom, $urandom};
            if (i % 1000 == 700) begin
                rst_n = 1'b0;
                idle();
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), a,
                  $urandom, 4'($urandom));
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
